rr_grant_engine: RTL and testbench

Grant stage of the round-robin arbiter. It takes a request vector and the one-hot priority pointer held by the rotating pointer register. It issues one registered one-hot grant and holds it until the owner releases. It then pulses a pointer-update strobe carrying the finished grant, so the pointer register can rotate it left by one and form the next priority.

---
 rtl/rr_grant_engine_pkg.sv | 29 ++
 rtl/rr_grant_engine_priority_select.sv | 34 +++
 rtl/rr_grant_engine.sv | 105 ++++++++++
 tb/tb_rr_grant_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_engine_pkg.sv
// Shared round-robin arbiter types and one-hot helpers.
// Used by the grant engine, the pointer register and the bench.
// Helpers are purely combinational and take vectors up to ARB_MAX_W bits.
package rr_grant_engine_pkg;

    localparam int ARB_MAX_W = 32;
    localparam int ARB_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RETIRE = 2'd2
    } arb_state_t;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic logic [ARB_MAX_W-1:0] lowest_set_bit(input logic [ARB_MAX_W-1:0] v);
        return v & (~v + ARB_MAX_W'(1));
    endfunction

    function automatic logic [ARB_IDX_W-1:0] onehot_to_index(input logic [ARB_MAX_W-1:0] v);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (v[i]) idx = ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_engine_priority_select.sv
// Circular priority encoder: first requester at or above the priority position, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is taken.
module rr_priority_select
    import rr_grant_engine_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         prio,
    output logic [WIDTH-1:0]         winner,
    output logic [$clog2(WIDTH)-1:0] winner_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int DW    = 2 * WIDTH;

    logic [WIDTH-1:0] prio_norm;
    logic [DW-1:0]    masked;
    logic [DW-1:0]    first;

    always_comb begin
        prio_norm = WIDTH'(lowest_set_bit(ARB_MAX_W'(prio)));
        if (prio_norm == '0) prio_norm = WIDTH'(1);
        // Upper copy is fully unmasked, so the scan wraps past WIDTH-1 back to bit 0.
        masked     = {req, req} & ~(DW'(prio_norm) - DW'(1));
        first      = DW'(lowest_set_bit(ARB_MAX_W'(masked)));
        winner     = first[WIDTH-1:0] | first[DW-1:WIDTH];
        winner_idx = IDX_W'(onehot_to_index(ARB_MAX_W'(winner)));
        any        = |req;
    end

endmodule

// File: rtl/rr_grant_engine.sv
// Round-robin grant stage: holds a one-hot grant until done, withdrawal or hold timeout, then strobes the pointer update.
// Latency: req to grant 1 cycle; release to next grant 2 idle cycles.
// Backpressure: a held grant blocks all other requesters until it is released.
module rr_grant_engine
    import rr_grant_engine_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         prio,
    input  logic                     done,
    output logic [WIDTH-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(WIDTH)-1:0] grant_idx,
    output logic                     ptr_load,
    output logic [WIDTH-1:0]         ptr_value,
    output logic                     timeout
);

    localparam int IDX_W = $clog2(WIDTH);

    arb_state_t       state, state_nxt;
    logic [WIDTH-1:0] sel_grant, grant_nxt, ptr_value_nxt;
    logic [IDX_W-1:0] sel_idx, idx_nxt;
    logic             sel_any, load_nxt, timeout_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             expired, withdrawn;

    rr_priority_select #(.WIDTH(WIDTH)) u_select (
        .req        (req),
        .prio       (prio),
        .winner     (sel_grant),
        .winner_idx (sel_idx),
        .any        (sel_any)
    );

    assign grant_valid = |grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            cnt       <= '0;
            ptr_load  <= 1'b0;
            ptr_value <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            cnt       <= cnt_nxt;
            ptr_load  <= load_nxt;
            ptr_value <= ptr_value_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        idx_nxt       = grant_idx;
        cnt_nxt       = cnt;
        load_nxt      = 1'b0;
        ptr_value_nxt = '0;
        timeout_nxt   = 1'b0;
        expired       = (cnt == CNT_W'(MAX_HOLD - 1));
        withdrawn     = !req[grant_idx];

        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    grant_nxt = sel_grant;
                    idx_nxt   = sel_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (done || withdrawn || expired) begin
                    grant_nxt     = '0;
                    idx_nxt       = '0;
                    cnt_nxt       = '0;
                    load_nxt      = 1'b1;
                    ptr_value_nxt = grant;
                    // Only an expiry with neither done nor withdrawal counts as forced.
                    timeout_nxt   = !done && !withdrawn;
                    state_nxt     = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_grant_engine.sv
// Directed scoreboard bench for rr_grant_engine (WIDTH=4, MAX_HOLD=16).
// Expected grants and pointer retirements are queued at stimulus time and popped as the DUT produces them.
module tb_rr_grant_engine;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
    } gexp_t;

    typedef struct packed {
        logic [3:0] value;
        logic       tmo;
    } lexp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] prio_drv = 4'b0;
    logic       loop_en = 1'b0;
    logic       done = 1'b0;
    logic [3:0] ptr_reg;
    logic [3:0] prio;

    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       ptr_load;
    logic [3:0] ptr_value;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;
    gexp_t gq[$];
    lexp_t lq[$];

    rr_grant_engine #(.WIDTH(4), .MAX_HOLD(16), .CNT_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .prio        (prio),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr_load    (ptr_load),
        .ptr_value   (ptr_value),
        .timeout     (timeout)
    );

    initial forever #5 clock = ~clock;

    // Model of the rotating pointer register closing the loop.
    always @(posedge clock or negedge reset) begin
        if (!reset)        ptr_reg <= 4'b0001;
        else if (ptr_load) ptr_reg <= {ptr_value[2:0], ptr_value[3]};
    end

    assign prio = loop_en ? ptr_reg : prio_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Waits (bounded) for grant_valid, counting idle cycles seen before it.
    task automatic wait_grant(input string tag, output int waited);
        gexp_t e;
        waited = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (grant_valid === 1'b1) break;
            waited++;
        end
        chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
        chk({tag, "_valid_eq_or"}, 32'(grant_valid), 32'(|grant));
        if (gq.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = gq.pop_front();
            chk({tag, "_grant"}, 32'(grant), 32'(e.grant));
            chk({tag, "_idx"}, 32'(grant_idx), 32'(e.idx));
        end
    endtask

    task automatic check_release(input string tag);
        lexp_t e;
        chk({tag, "_ptr_load"}, 32'(ptr_load), 32'd1);
        chk({tag, "_gv_low"}, 32'(grant_valid), 32'd0);
        chk({tag, "_grant_zero"}, 32'(grant), 32'd0);
        if (lq.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = lq.pop_front();
            chk({tag, "_ptr_value"}, 32'(ptr_value), 32'(e.value));
            chk({tag, "_timeout"}, 32'(timeout), 32'(e.tmo));
        end
    endtask

    task automatic release_done();
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
    endtask

    initial begin
        int w;
        int held;

        // Reset state
        @(negedge clock);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_gv", 32'(grant_valid), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_load", 32'(ptr_load), 32'd0);
        chk("rst_value", 32'(ptr_value), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        reset = 1'b1;
        idle(1);

        // Reset asserted mid-BUSY clears outputs without waiting for an edge
        prio_drv = 4'b0100;
        req = 4'b0100;
        gq.push_back('{grant: 4'b0100, idx: 2'd2});
        wait_grant("t1", w);
        chk("t1_latency", 32'(w), 32'd0);
        idle(2);
        #2 reset = 1'b0;
        #1;
        chk("t1_mid_grant", 32'(grant), 32'd0);
        chk("t1_mid_gv", 32'(grant_valid), 32'd0);
        chk("t1_mid_idx", 32'(grant_idx), 32'd0);
        chk("t1_mid_load", 32'(ptr_load), 32'd0);
        chk("t1_mid_tmo", 32'(timeout), 32'd0);
        req = 4'b0;
        @(negedge clock);
        reset = 1'b1;
        idle(3);
        chk("t1_post_gv", 32'(grant_valid), 32'd0);
        chk("t1_post_load", 32'(ptr_load), 32'd0);

        // All requesting, pointer register in loop: strict rotation with 2-cycle gaps
        loop_en = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            gq.push_back('{grant: g, idx: 2'(i % 4)});
            wait_grant("t3", w);
            chk("t3_gap", 32'(w), (i == 0) ? 32'd0 : 32'd1);
            lq.push_back('{value: g, tmo: 1'b0});
            release_done();
            check_release("t3_rel");
        end
        req = 4'b0;
        loop_en = 1'b0;
        idle(2);

        // req=1010 prio=0100 wraps to bit 3; then prio=0001 picks bit 1
        prio_drv = 4'b0100;
        req = 4'b1010;
        gq.push_back('{grant: 4'b1000, idx: 2'd3});
        wait_grant("t2", w);
        chk("t2_latency", 32'(w), 32'd0);
        idle(2);
        lq.push_back('{value: 4'b1000, tmo: 1'b0});
        release_done();
        check_release("t2_rel");
        prio_drv = 4'b0001;
        gq.push_back('{grant: 4'b0010, idx: 2'd1});
        wait_grant("t2b", w);
        chk("t2b_gap", 32'(w), 32'd1);
        lq.push_back('{value: 4'b0010, tmo: 1'b0});
        release_done();
        check_release("t2b_rel");
        req = 4'b0;
        idle(2);

        // Single requester, no done: forced release after MAX_HOLD cycles
        prio_drv = 4'b0001;
        req = 4'b0001;
        gq.push_back('{grant: 4'b0001, idx: 2'd0});
        wait_grant("t4", w);
        held = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (grant_valid !== 1'b1) break;
            held++;
        end
        chk("t4_held", 32'(held), 32'd16);
        lq.push_back('{value: 4'b0001, tmo: 1'b1});
        check_release("t4_rel");
        gq.push_back('{grant: 4'b0001, idx: 2'd0});
        wait_grant("t4b", w);
        chk("t4b_gap", 32'(w), 32'd1);

        // done coinciding with counter expiry: normal release, no timeout
        idle(15);
        lq.push_back('{value: 4'b0001, tmo: 1'b0});
        release_done();
        check_release("t5_rel");
        req = 4'b0;
        idle(2);

        // Granted requester withdraws; other req bits do not hold the grant
        prio_drv = 4'b0100;
        req = 4'b0101;
        gq.push_back('{grant: 4'b0100, idx: 2'd2});
        wait_grant("t6", w);
        req = 4'b0001;
        @(negedge clock);
        lq.push_back('{value: 4'b0100, tmo: 1'b0});
        check_release("t6_rel");

        // Zero priority behaves as bit 0
        prio_drv = 4'b0000;
        req = 4'b0110;
        gq.push_back('{grant: 4'b0010, idx: 2'd1});
        wait_grant("t6z", w);
        chk("t6z_gap", 32'(w), 32'd1);
        lq.push_back('{value: 4'b0010, tmo: 1'b0});
        release_done();
        check_release("t6z_rel");

        // Multi-bit priority uses its lowest bit (bit 1), scan wraps to bit 3
        prio_drv = 4'b1010;
        req = 4'b1001;
        gq.push_back('{grant: 4'b1000, idx: 2'd3});
        wait_grant("t7", w);
        lq.push_back('{value: 4'b1000, tmo: 1'b0});
        release_done();
        check_release("t7_rel");
        req = 4'b0;
        idle(1);
        chk("t7_load_pulse", 32'(ptr_load), 32'd0);
        idle(2);
        chk("end_idle_gv", 32'(grant_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
